// File: rtl/complex_pkg.sv
// Shared complex-lane types and helpers for the complex adder/subtractor datapath.
// Lane helpers take a sign-extended difference plus the lane width so any width up to LANE_MAXW works.
package complex_pkg;

  localparam int LANE_W    = 8;
  localparam int LANE_MAXW = 32;

  typedef logic signed [LANE_W-1:0] lane_t;
  typedef struct packed {
    lane_t re;
    lane_t im;
  } cplx_t;

  localparam lane_t LANE_MAX = lane_t'((2 ** (LANE_W - 1)) - 1);
  localparam lane_t LANE_MIN = lane_t'(-(2 ** (LANE_W - 1)));

  typedef logic [LANE_MAXW:0] wide_t;

  // A w-bit lane overflowed when the two top bits of its w+1-bit difference disagree.
  function automatic logic lane_ovf(input wide_t d, input logic [5:0] w);
    return d[w] != d[w - 6'd1];
  endfunction

  function automatic logic [LANE_MAXW-1:0] lane_sat(input wide_t d, input logic [5:0] w,
                                                    input bit sat);
    logic [LANE_MAXW-1:0] ones;
    ones = '1;
    if (sat && lane_ovf(d, w)) begin
      return d[w] ? (ones << (w - 6'd1)) : ~(ones << (w - 6'd1));
    end
    return d[LANE_MAXW-1:0];
  endfunction

endpackage

// File: rtl/sub_lane.sv
// One lane of the complex subtractor: S1 holds the W+1-bit difference,
// S2 holds the saturated or wrapped W-bit result and its overflow flag.
module sub_lane
  import complex_pkg::*;
#(
  parameter int W        = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en1,
  input  logic         en2,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic         ovf
);

  logic [W:0]   diff;
  wide_t        diff_ext;
  logic [W-1:0] res;

  assign diff_ext = {{(LANE_MAXW - W){diff[W]}}, diff};
  assign res      = W'(lane_sat(diff_ext, 6'(W), SATURATE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff <= '0;
      c    <= '0;
      ovf  <= 1'b0;
    end else begin
      if (en1) begin
        diff <= {a[W-1], a} - {b[W-1], b};
      end
      if (en2) begin
        c   <= res;
        ovf <= lane_ovf(diff_ext, 6'(W));
      end
    end
  end

endmodule

// File: rtl/complex_sub_pipe.sv
// Two-stage pipelined complex subtractor c = a - b with valid/ready backpressure.
// Both lanes share one handshake controller so real and imag always move together.
module complex_sub_pipe
  import complex_pkg::*;
#(
  parameter int BITS     = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] c,
  output logic [1:0]      out_ovf
);

  localparam int W = BITS / 2;

  logic v1, v2;
  logic adv1, adv2;
  logic en1, en2;

  // A stage may advance when it is empty or the stage after it is advancing.
  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign en1       = adv1 && in_valid;
  assign en2       = adv2 && v1;
  assign out_valid = v2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv2) v2 <= v1;
    end
  end

  sub_lane #(.W(W), .SATURATE(SATURATE)) u_re (
    .clk (clk),
    .rst (rst),
    .en1 (en1),
    .en2 (en2),
    .a   (a[BITS-1:W]),
    .b   (b[BITS-1:W]),
    .c   (c[BITS-1:W]),
    .ovf (out_ovf[1])
  );

  sub_lane #(.W(W), .SATURATE(SATURATE)) u_im (
    .clk (clk),
    .rst (rst),
    .en1 (en1),
    .en2 (en2),
    .a   (a[W-1:0]),
    .b   (b[W-1:0]),
    .c   (c[W-1:0]),
    .ovf (out_ovf[0])
  );

endmodule
